// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states and default widths.
package pipe_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_CTRL_WIDTH = 16;
   localparam int DEF_CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry (valid, ctrl, data). Clearing drops valid and zeroes ctrl
// but keeps data, so the payload output holds its last value while empty.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [CTRL_WIDTH-1:0] ctrl_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   output logic [CTRL_WIDTH-1:0] ctrl_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic                  valid_q;
   logic [CTRL_WIDTH-1:0] ctrl_q;
   logic [DATA_WIDTH-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         ctrl_q  <= ctrl_i;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, freeze, flush and a saturating stall counter.
//   state | meaning
//   EMPTY | no entry held
//   ONE   | head entry held, skid slot free
//   FULL  | head and skid entries held, upstream blocked
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
   parameter int SKID       = 0,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  BUSYWAIT,
   input  logic                  FLUSH,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [CTRL_WIDTH-1:0] IN_CTRL,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [CTRL_WIDTH-1:0] OUT_CTRL,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic [CNT_WIDTH-1:0]  STALL_CNT
);

   logic                  accept, pop;
   logic                  head_load, head_clear;
   logic                  head_valid;
   logic [CTRL_WIDTH-1:0] head_ctrl, head_ctrl_d;
   logic [DATA_WIDTH-1:0] head_data, head_data_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

   assign accept = IN_VALID & IN_READY & ~BUSYWAIT & ~FLUSH;
   assign pop    = head_valid & OUT_READY & ~BUSYWAIT & ~FLUSH;

   pipe_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_head (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .clear_i (head_clear),
      .load_i  (head_load),
      .ctrl_i  (head_ctrl_d),
      .data_i  (head_data_d),
      .valid_o (head_valid),
      .ctrl_o  (head_ctrl),
      .data_o  (head_data)
   );

   generate
      if (SKID == 0) begin : g_single
         assign IN_READY    = ~BUSYWAIT & (~head_valid | OUT_READY);
         assign head_load   = accept;
         assign head_clear  = FLUSH | (pop & ~accept);
         assign head_ctrl_d = IN_CTRL;
         assign head_data_d = IN_DATA;
      end else begin : g_skid
         pipe_state_e           state_q, state_d;
         logic                  in_ready_q;
         logic                  skid_load, skid_clear, head_from_skid;
         logic                  skid_valid_unused;
         logic [CTRL_WIDTH-1:0] skid_ctrl;
         logic [DATA_WIDTH-1:0] skid_data;

         pipe_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_skid (
            .clk_i   (CLK),
            .rst_i   (RESET),
            .clear_i (skid_clear),
            .load_i  (skid_load),
            .ctrl_i  (IN_CTRL),
            .data_i  (IN_DATA),
            .valid_o (skid_valid_unused),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data)
         );

         // Ready is a flop so OUT_READY never reaches IN_READY combinationally.
         always_ff @(posedge CLK) begin
            if (RESET) begin
               state_q    <= EMPTY;
               in_ready_q <= 1'b1;
            end else begin
               state_q    <= state_d;
               in_ready_q <= (state_d != FULL);
            end
         end

         always_comb begin
            state_d        = state_q;
            head_load      = 1'b0;
            head_clear     = 1'b0;
            skid_load      = 1'b0;
            skid_clear     = 1'b0;
            head_from_skid = 1'b0;
            if (FLUSH) begin
               state_d    = EMPTY;
               head_clear = 1'b1;
               skid_clear = 1'b1;
            end else begin
               case (state_q)
                  EMPTY: if (accept) begin
                     state_d   = ONE;
                     head_load = 1'b1;
                  end
                  ONE: begin
                     if (accept && pop) begin
                        head_load = 1'b1;
                     end else if (accept) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                     end else if (pop) begin
                        state_d    = EMPTY;
                        head_clear = 1'b1;
                     end
                  end
                  FULL: if (pop) begin
                     state_d        = ONE;
                     head_load      = 1'b1;
                     head_from_skid = 1'b1;
                     skid_clear     = 1'b1;
                  end
                  default: state_d = EMPTY;
               endcase
            end
         end

         assign IN_READY    = in_ready_q;
         assign head_ctrl_d = head_from_skid ? skid_ctrl : IN_CTRL;
         assign head_data_d = head_from_skid ? skid_data : IN_DATA;
      end
   endgenerate

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (head_valid && (!OUT_READY || BUSYWAIT) && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign OUT_VALID = head_valid;
   assign OUT_CTRL  = head_ctrl;
   assign OUT_DATA  = head_data;
   assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: single-entry stage (dut0), skid stage (dut1) and a 4-bit counter stage (dut2) on shared inputs.
module tb_pipe_stage_reg;

   logic        clk, rst, bw, fl, iv, ordy;
   logic [15:0] ic;
   logic [31:0] id;

   logic        ir0, ov0, ir1, ov1, ir2, ov2;
   logic [15:0] oc0, oc1, oc2, sc0, sc1;
   logic [31:0] od0, od1, od2;
   logic [3:0]  sc2;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .SKID(0), .CNT_WIDTH(16)) dut0 (
      .CLK(clk), .RESET(rst), .BUSYWAIT(bw), .FLUSH(fl), .IN_VALID(iv), .IN_READY(ir0),
      .IN_CTRL(ic), .IN_DATA(id), .OUT_VALID(ov0), .OUT_READY(ordy), .OUT_CTRL(oc0),
      .OUT_DATA(od0), .STALL_CNT(sc0));

   pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .SKID(1), .CNT_WIDTH(16)) dut1 (
      .CLK(clk), .RESET(rst), .BUSYWAIT(bw), .FLUSH(fl), .IN_VALID(iv), .IN_READY(ir1),
      .IN_CTRL(ic), .IN_DATA(id), .OUT_VALID(ov1), .OUT_READY(ordy), .OUT_CTRL(oc1),
      .OUT_DATA(od1), .STALL_CNT(sc1));

   pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .SKID(0), .CNT_WIDTH(4)) dut2 (
      .CLK(clk), .RESET(rst), .BUSYWAIT(bw), .FLUSH(fl), .IN_VALID(iv), .IN_READY(ir2),
      .IN_CTRL(ic), .IN_DATA(id), .OUT_VALID(ov2), .OUT_READY(ordy), .OUT_CTRL(oc2),
      .OUT_DATA(od2), .STALL_CNT(sc2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; bw = 1'b0; fl = 1'b0; iv = 1'b0; ordy = 1'b0; ic = '0; id = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; bw = 1'b0; fl = 1'b0; iv = 1'b1; ordy = 1'b0; ic = 16'hFFFF; id = 32'hFFFF_FFFF;
      tick();
      checks++; if (ov0 !== 1'b0 || ov1 !== 1'b0 || ov2 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b%b%b exp 000", ov0, ov1, ov2); end
      checks++; if (oc0 !== 16'h0 || oc1 !== 16'h0 || oc2 !== 16'h0) begin errors++; $display("FAIL rst_ctrl got %h %h %h exp 0", oc0, oc1, oc2); end
      checks++; if (od0 !== 32'h0 || od1 !== 32'h0 || od2 !== 32'h0) begin errors++; $display("FAIL rst_data got %h %h %h exp 0", od0, od1, od2); end
      checks++; if (sc0 !== 16'h0 || sc1 !== 16'h0 || sc2 !== 4'h0) begin errors++; $display("FAIL rst_cnt got %h %h %h exp 0", sc0, sc1, sc2); end
      checks++; if (ir0 !== 1'b1 || ir1 !== 1'b1 || ir2 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b%b%b exp 111", ir0, ir1, ir2); end
      bw = 1'b1;
      #1;
      checks++; if (ir0 !== 1'b0 || ir1 !== 1'b1) begin errors++; $display("FAIL rst_ready_bw got %b%b exp 01", ir0, ir1); end
      rst = 1'b0; bw = 1'b0; iv = 1'b0;
   endtask

   task automatic test_pass_through;
      logic [31:0] exp_d;
      logic [15:0] exp_c;
      do_reset();
      ordy = 1'b1; iv = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_d = 32'h0000_0010 + 32'(i);
         exp_c = 16'h0100 + 16'(i);
         id = exp_d; ic = exp_c;
         tick();
         checks++; if (ov0 !== 1'b1 || od0 !== exp_d || oc0 !== exp_c) begin errors++; $display("FAIL b2b_s0[%0d] got v=%b d=%h c=%h exp d=%h c=%h", i, ov0, od0, oc0, exp_d, exp_c); end
         checks++; if (ov1 !== 1'b1 || od1 !== exp_d || oc1 !== exp_c) begin errors++; $display("FAIL b2b_s1[%0d] got v=%b d=%h c=%h exp d=%h c=%h", i, ov1, od1, oc1, exp_d, exp_c); end
      end
      iv = 1'b0;
      tick();
      checks++; if (ov0 !== 1'b0 || oc0 !== 16'h0 || od0 !== 32'h13) begin errors++; $display("FAIL b2b_drain got v=%b c=%h d=%h exp 0 0 13", ov0, oc0, od0); end
      checks++; if (sc0 !== 16'd0 || ov1 !== 1'b0) begin errors++; $display("FAIL b2b_cnt got cnt=%0d v1=%b exp 0 0", sc0, ov1); end
   endtask

   task automatic test_zero_ctrl_flush;
      do_reset();
      iv = 1'b1; ic = 16'h0; id = 32'h77;
      tick();
      checks++; if (ov0 !== 1'b1 || oc0 !== 16'h0 || od0 !== 32'h77) begin errors++; $display("FAIL zero_ctrl got v=%b c=%h d=%h exp 1 0 77", ov0, oc0, od0); end
      fl = 1'b1; id = 32'h88; ic = 16'h1;
      tick();
      checks++; if (ov0 !== 1'b0 || oc0 !== 16'h0 || od0 !== 32'h77) begin errors++; $display("FAIL flush_s0 got v=%b c=%h d=%h exp 0 0 77", ov0, oc0, od0); end
      fl = 1'b0; iv = 1'b0;
   endtask

   task automatic test_skid_full;
      do_reset();
      iv = 1'b1; id = 32'hAAAA_0001; ic = 16'h00A1;
      tick();
      checks++; if (ir1 !== 1'b1 || od1 !== 32'hAAAA_0001) begin errors++; $display("FAIL skid_one got rdy=%b d=%h exp 1 AAAA0001", ir1, od1); end
      id = 32'hBBBB_0002; ic = 16'h00B2;
      tick();
      checks++; if (ir1 !== 1'b0 || ov1 !== 1'b1 || od1 !== 32'hAAAA_0001) begin errors++; $display("FAIL skid_full got rdy=%b v=%b d=%h exp 0 1 AAAA0001", ir1, ov1, od1); end
      id = 32'hCCCC_0003; ic = 16'h00C3;
      tick();
      checks++; if (ir1 !== 1'b0 || od1 !== 32'hAAAA_0001 || sc1 !== 16'd2) begin errors++; $display("FAIL skid_hold got rdy=%b d=%h cnt=%0d exp 0 AAAA0001 2", ir1, od1, sc1); end
      iv = 1'b0; ordy = 1'b1;
      tick();
      checks++; if (ov1 !== 1'b1 || od1 !== 32'hBBBB_0002 || oc1 !== 16'h00B2 || ir1 !== 1'b1) begin errors++; $display("FAIL skid_pop_b got v=%b d=%h c=%h rdy=%b exp 1 BBBB0002 00B2 1", ov1, od1, oc1, ir1); end
      tick();
      checks++; if (ov1 !== 1'b0 || oc1 !== 16'h0 || od1 !== 32'hBBBB_0002 || sc1 !== 16'd2) begin errors++; $display("FAIL skid_empty got v=%b c=%h d=%h cnt=%0d exp 0 0 BBBB0002 2", ov1, oc1, od1, sc1); end
   endtask

   task automatic test_busywait;
      do_reset();
      iv = 1'b1; id = 32'h0000_D00D; ic = 16'h00D0;
      tick();
      bw = 1'b1; ordy = 1'b1; id = 32'h0000_EEEE; ic = 16'h00EE;
      #1;
      checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bw_ready_s0 got %b exp 0", ir0); end
      for (int i = 0; i < 3; i++) tick();
      checks++; if (ov1 !== 1'b1 || od1 !== 32'h0000_D00D || oc1 !== 16'h00D0) begin errors++; $display("FAIL bw_head got v=%b d=%h c=%h exp 1 D00D 00D0", ov1, od1, oc1); end
      checks++; if (sc1 !== 16'd3 || sc0 !== 16'd3 || ir1 !== 1'b1) begin errors++; $display("FAIL bw_cnt got s1=%0d s0=%0d rdy=%b exp 3 3 1", sc1, sc0, ir1); end
      bw = 1'b0; iv = 1'b0;
      tick();
      checks++; if (ov1 !== 1'b0 || sc1 !== 16'd3) begin errors++; $display("FAIL bw_release got v=%b cnt=%0d exp 0 3", ov1, sc1); end
      ordy = 1'b0;
   endtask

   task automatic test_flush_busywait;
      do_reset();
      iv = 1'b1; id = 32'hAAAA_0001; ic = 16'h00A1;
      tick();
      id = 32'hBBBB_0002; ic = 16'h00B2;
      tick();
      fl = 1'b1; bw = 1'b1; id = 32'hCCCC_0003; ic = 16'h00C3;
      tick();
      checks++; if (ov1 !== 1'b0 || oc1 !== 16'h0 || ir1 !== 1'b1) begin errors++; $display("FAIL flush_bw got v=%b c=%h rdy=%b exp 0 0 1", ov1, oc1, ir1); end
      checks++; if (od1 !== 32'hAAAA_0001 || sc1 !== 16'd2) begin errors++; $display("FAIL flush_hold got d=%h cnt=%0d exp AAAA0001 2", od1, sc1); end
      fl = 1'b0; bw = 1'b0; ordy = 1'b1; id = 32'hF00D_0004; ic = 16'h00F4;
      tick();
      checks++; if (ov1 !== 1'b1 || od1 !== 32'hF00D_0004 || oc1 !== 16'h00F4) begin errors++; $display("FAIL flush_next got v=%b d=%h c=%h exp 1 F00D0004 00F4", ov1, od1, oc1); end
      iv = 1'b0;
      tick();
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_drain got v=%b exp 0", ov1); end
      ordy = 1'b0;
   endtask

   task automatic test_saturation;
      do_reset();
      iv = 1'b1; id = 32'h55; ic = 16'h5;
      tick();
      iv = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) begin
            checks++; if (sc2 !== 4'd14) begin errors++; $display("FAIL sat_mid got %0d exp 14", sc2); end
         end
      end
      checks++; if (sc2 !== 4'd15) begin errors++; $display("FAIL sat_end got %0d exp 15", sc2); end
      checks++; if (sc0 !== 16'd20 || ov2 !== 1'b1 || od2 !== 32'h55) begin errors++; $display("FAIL sat_wide got cnt=%0d v=%b d=%h exp 20 1 55", sc0, ov2, od2); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      iv = 1'b1; id = 32'hAAAA_0001; ic = 16'h00A1;
      tick();
      id = 32'hBBBB_0002; ic = 16'h00B2;
      tick();
      rst = 1'b1; id = 32'hCCCC_0003; ic = 16'h00C3;
      tick();
      checks++; if (ov1 !== 1'b0 || oc1 !== 16'h0 || od1 !== 32'h0 || sc1 !== 16'h0 || ir1 !== 1'b1) begin errors++; $display("FAIL rstmid got v=%b c=%h d=%h cnt=%0d rdy=%b exp 0 0 0 0 1", ov1, oc1, od1, sc1, ir1); end
      rst = 1'b0; id = 32'h1234_5678; ic = 16'h0005;
      tick();
      iv = 1'b0; ordy = 1'b1;
      checks++; if (ov1 !== 1'b1 || od1 !== 32'h1234_5678 || oc1 !== 16'h0005) begin errors++; $display("FAIL rstmid_first got v=%b d=%h c=%h exp 1 12345678 0005", ov1, od1, oc1); end
      tick();
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL rstmid_gone got v=%b d=%h exp 0", ov1, od1); end
      ordy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_zero_ctrl_flush();
      test_skid_full();
      test_busywait();
      test_flush_busywait();
      test_saturation();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the datapath payload (operands, PC, immediate bundle).
REQ-002 Parameter CTRL_WIDTH, default 16: width of the control-signal bundle (write-enable, mem-read/write, branch, jump, ALUOP, etc.).
REQ-003 Parameter SKID, default 0: 0 = single-entry stage, 1 = two-entry skid stage.
REQ-004 Parameter CNT_WIDTH, default 16: width of the stall counter.
REQ-005 CLK  input  1  clock; all state updates on the rising edge.
REQ-006 RESET  input  1  reset; synchronous, active-high.
REQ-007 BUSYWAIT  input  1  global freeze from the memory subsystem.
REQ-008 FLUSH  input  1  discard all held entries and insert a bubble.
REQ-009 IN_VALID  input  1  upstream entry present.
REQ-010 IN_READY  output  1  stage accepts an entry this cycle.
REQ-011 IN_CTRL  input  CTRL_WIDTH  upstream control bundle.
REQ-012 IN_DATA  input  DATA_WIDTH  upstream payload.
REQ-013 OUT_VALID  output  1  head entry valid.
REQ-014 OUT_READY  input  1  downstream consumes the head this cycle.
REQ-015 OUT_CTRL  output  CTRL_WIDTH  head control bundle; all zeros whenever OUT_VALID=0.
REQ-016 OUT_DATA  output  DATA_WIDTH  head payload; holds its last value when invalid.
REQ-017 STALL_CNT  output  CNT_WIDTH  saturating count of cycles with OUT_VALID=1 and (OUT_READY=0 or BUSYWAIT=1).

Function
REQ-018 Accept = IN_VALID & IN_READY & !BUSYWAIT & !FLUSH; pop = OUT_VALID & OUT_READY & !BUSYWAIT & !FLUSH.
REQ-019 Priority per edge: RESET > FLUSH > BUSYWAIT > accept/pop.
REQ-020 BUSYWAIT=1: no entry, flag, or data register changes; only STALL_CNT updates.
REQ-021 FLUSH=1: the next edge leaves the stage empty (OUT_VALID=0, OUT_CTRL=0), even when BUSYWAIT=1; any entry offered in the same cycle is dropped.
REQ-022 SKID=0: IN_READY = !BUSYWAIT & (!OUT_VALID | OUT_READY) (combinational); latency 1 cycle; simultaneous pop and accept replace the head, giving full throughput.
REQ-023 SKID=1: states EMPTY, ONE, FULL; IN_READY = (state != FULL), registered, with no combinational path from OUT_READY.
REQ-024 SKID=1 transitions: EMPTY -accept-> ONE; ONE -accept&!pop-> FULL; ONE -pop&!accept-> EMPTY; ONE -accept&pop-> ONE (head replaced); FULL -pop-> ONE (skid entry moves to head); FULL ignores IN_VALID.
REQ-025 SKID=1 ordering: entries leave strictly in arrival order; latency 1 cycle when EMPTY.
REQ-026 Data and control of an entry are captured together and never mixed across entries.
REQ-027 STALL_CNT increments by 1 per qualifying cycle, saturates at 2^CNT_WIDTH-1, and is unaffected by FLUSH.
REQ-028 Entries accepted with IN_CTRL=0 are legal and propagate as ordinary entries.

Reset
REQ-029 After a RESET edge: state EMPTY, OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, STALL_CNT=0, skid entry cleared.
REQ-030 After a RESET edge: IN_READY=1 for SKID=1; for SKID=0, IN_READY=!BUSYWAIT.
REQ-031 RESET asserted mid-transfer discards every held entry; no partial entry survives.

Structure
REQ-032 Shared package pipe_pkg holds the state enumeration (EMPTY, ONE, FULL) and the default width constants.
REQ-033 One sub-module, pipe_slot: a single entry holding valid, ctrl, and data, with load and clear controls; it is instantiated once for SKID=0 and twice (head, skid) for SKID=1.
REQ-034 Target size is 120-400 lines of RTL; no memories and no latches.

Verification
REQ-035 SKID=0, DATA=0x00000010..0x00000013 offered back-to-back, OUT_READY=1 -> the four values appear on consecutive cycles with 1-cycle latency and STALL_CNT=0.
REQ-036 SKID=1, OUT_READY held 0, entries A=0xAAAA0001 and B=0xBBBB0002 offered -> state FULL, IN_READY=0 on the next cycle; OUT_READY=1 then yields A, then B, with none lost.
REQ-037 ONE state, BUSYWAIT=1 for 3 cycles with IN_VALID=1 and OUT_READY=1 -> no pop or accept occurs, the head is unchanged, and STALL_CNT increases by 3.
REQ-038 FULL state, FLUSH=1 and BUSYWAIT=1 in the same cycle -> next cycle OUT_VALID=0, OUT_CTRL=0, and IN_READY=1 for SKID=1.
REQ-039 CNT_WIDTH=4, 20 stalled cycles -> STALL_CNT=15 and holds there.
REQ-040 RESET pulsed while in FULL with IN_VALID=1 -> next cycle EMPTY with all outputs 0; the first entry accepted afterwards is the first to exit.
